// File: rtl/clock_counter_bank.sv
// rtl/clock_counter_bank.sv - multi-channel cycle counter bank with snapshot, compare match and overflow flags
module clock_counter_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [31:0]               command,
    input  logic [WIDTH-1:0]          operand,
    output logic [CHANNELS*WIDTH-1:0] count_bus,
    output logic [CHANNELS*WIDTH-1:0] snap_bus,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       overflow,
    output logic [CHANNELS-1:0]       match,
    output logic                      irq
);

    localparam logic [3:0] OP_CLEAR     = 4'd0;
    localparam logic [3:0] OP_START     = 4'd1;
    localparam logic [3:0] OP_STOP      = 4'd2;
    localparam logic [3:0] OP_SNAP      = 4'd3;
    localparam logic [3:0] OP_LOAD_CMP  = 4'd4;
    localparam logic [3:0] OP_CLR_FLAGS = 4'd5;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [3:0] opcode;
    logic       unused_cmd;

    assign opcode     = command[3:0];
    assign unused_cmd = ^{command[31:17], command[15:12], command[7:4]};

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] snap_q;
        logic [WIDTH-1:0] cmp_q;
        logic             run_q;
        logic             ovf_q;
        logic             mat_q;
        logic [WIDTH-1:0] cnt_next;
        logic             hit;
        logic             wrap_evt;
        logic             match_evt;

        // An out-of-range index never equals any channel number, so it targets nothing.
        assign hit       = enable && (command[16] || (command[11:8] == 4'(ch)));
        assign cnt_next  = cnt_q + ONE;
        assign wrap_evt  = run_q && (cnt_q == {WIDTH{1'b1}});
        assign match_evt = run_q && (cnt_next == cmp_q);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                snap_q <= '0;
                cmp_q  <= '1;
                run_q  <= 1'b0;
                ovf_q  <= 1'b0;
                mat_q  <= 1'b0;
            end else if (hit && opcode == OP_CLEAR) begin
                cnt_q <= '0;
                run_q <= 1'b0;
                ovf_q <= 1'b0;
                mat_q <= 1'b0;
            end else begin
                if (run_q) begin
                    cnt_q <= cnt_next;
                end
                // A flag event on the clearing edge survives the clear.
                if (hit && opcode == OP_CLR_FLAGS) begin
                    ovf_q <= wrap_evt;
                    mat_q <= match_evt;
                end else begin
                    ovf_q <= ovf_q | wrap_evt;
                    mat_q <= mat_q | match_evt;
                end
                if (hit) begin
                    case (opcode)
                        OP_START:    run_q  <= 1'b1;
                        OP_STOP:     run_q  <= 1'b0;
                        OP_SNAP:     snap_q <= cnt_q;
                        OP_LOAD_CMP: cmp_q  <= operand;
                        default:     ;
                    endcase
                end
            end
        end

        assign count_bus[ch*WIDTH +: WIDTH] = cnt_q;
        assign snap_bus[ch*WIDTH +: WIDTH]  = snap_q;
        assign running[ch]                  = run_q;
        assign overflow[ch]                 = ovf_q;
        assign match[ch]                    = mat_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |{overflow, match};
        end
    end

endmodule

// File: tb/tb_clock_counter_bank.sv
// tb/tb_clock_counter_bank.sv - scoreboard bench for clock_counter_bank
module tb_clock_counter_bank;

    localparam int W  = 8;
    localparam int CH = 4;

    localparam int K_COUNT = 0, K_SNAP = 1, K_RUN = 2, K_OVF = 3, K_MAT = 4, K_IRQ = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [31:0]       command = '0;
    logic [W-1:0]      operand = '0;
    logic [CH*W-1:0]   count_bus;
    logic [CH*W-1:0]   snap_bus;
    logic [CH-1:0]     running;
    logic [CH-1:0]     overflow;
    logic [CH-1:0]     match;
    logic              irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        int           kind;
        int           ch;
        logic [W-1:0] exp;
    } exp_t;

    exp_t sb[$];

    clock_counter_bank #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .command(command),
        .operand(operand), .count_bus(count_bus), .snap_bus(snap_bus),
        .running(running), .overflow(overflow), .match(match), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] observe(int kind, int ch);
        case (kind)
            K_COUNT: return count_bus[ch*W +: W];
            K_SNAP:  return snap_bus[ch*W +: W];
            K_RUN:   return W'(running[ch]);
            K_OVF:   return W'(overflow[ch]);
            K_MAT:   return W'(match[ch]);
            default: return W'(irq);
        endcase
    endfunction

    // Monitor: drains every pending expectation against the outputs at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [W-1:0] act;
            e   = sb.pop_front();
            act = observe(e.kind, e.ch);
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s ch%0d: actual %0d required %0d", e.name, e.ch, act, e.exp);
            end
        end
    end

    task automatic expect_val(string name, int kind, int ch, int value);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.ch   = ch;
        e.exp  = W'(value);
        sb.push_back(e);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic cmd(int op, int ch, bit bc, int opnd);
        command = '0;
        command[3:0]  = 4'(op);
        command[11:8] = 4'(ch);
        command[16]   = bc;
        operand = W'(opnd);
        enable  = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            expect_val("rst_count", K_COUNT, c, 0);
            expect_val("rst_snap", K_SNAP, c, 0);
            expect_val("rst_run", K_RUN, c, 0);
        end
        expect_val("rst_irq", K_IRQ, 0, 0);
        sync();
        reset_n = 1'b1;

        // Reset mid-count; compare must return to all-ones
        cmd(4, 0, 0, 5);  sync();
        cmd(1, 0, 0, 0);  sync();
        run(10);
        expect_val("pre_rst_count", K_COUNT, 0, 10);
        expect_val("pre_rst_match", K_MAT, 0, 1);
        sync();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        expect_val("async_rst_count", K_COUNT, 0, 0);
        expect_val("async_rst_run", K_RUN, 0, 0);
        expect_val("async_rst_match", K_MAT, 0, 0);
        sync();
        reset_n = 1'b1;
        cmd(1, 0, 0, 0);  sync();
        run(10);
        expect_val("post_rst_count", K_COUNT, 0, 10);
        expect_val("post_rst_nomatch", K_MAT, 0, 0);
        sync();

        // Start/stop accuracy
        do_reset();
        cmd(1, 1, 0, 0);  sync();
        run(24);          sync();
        cmd(2, 1, 0, 0);
        expect_val("ss_count", K_COUNT, 1, 25);
        expect_val("ss_run", K_RUN, 1, 0);
        expect_val("ss_other0", K_COUNT, 0, 0);
        expect_val("ss_other3", K_COUNT, 3, 0);
        sync();

        // Broadcast start plus snapshot
        do_reset();
        cmd(1, 0, 1, 0);  sync();
        run(6);           sync();
        cmd(3, 2, 0, 0);
        expect_val("bc_snap", K_SNAP, 2, 6);
        expect_val("bc_count", K_COUNT, 2, 7);
        sync();
        run(3);
        expect_val("bc_count_later", K_COUNT, 2, 10);
        expect_val("bc_snap_held", K_SNAP, 2, 6);
        expect_val("bc_count_ch0", K_COUNT, 0, 10);
        expect_val("bc_snap_ch0", K_SNAP, 0, 0);
        sync();

        // Wrap and overflow; reset compare of all-ones matches at 255
        do_reset();
        cmd(1, 3, 0, 0);  sync();
        run(255);
        expect_val("wrap_255", K_COUNT, 3, 255);
        expect_val("wrap_ff_match", K_MAT, 3, 1);
        expect_val("wrap_no_ovf", K_OVF, 3, 0);
        sync();
        run(1);
        expect_val("wrap_zero", K_COUNT, 3, 0);
        expect_val("wrap_ovf", K_OVF, 3, 1);
        sync();
        run(1);
        expect_val("wrap_irq", K_IRQ, 0, 1);
        sync();
        cmd(5, 3, 0, 0);
        expect_val("clrf_ovf", K_OVF, 3, 0);
        expect_val("clrf_match", K_MAT, 3, 0);
        expect_val("clrf_count", K_COUNT, 3, 2);
        expect_val("clrf_run", K_RUN, 3, 1);
        sync();
        run(1);
        expect_val("clrf_irq_low", K_IRQ, 0, 0);
        sync();

        // CLR_FLAGS on the wrap edge keeps overflow
        run(252);
        expect_val("cc_255", K_COUNT, 3, 255);
        sync();
        cmd(5, 3, 0, 0);
        expect_val("cc_ovf_kept", K_OVF, 3, 1);
        expect_val("cc_match_cleared", K_MAT, 3, 0);
        expect_val("cc_count", K_COUNT, 3, 0);
        sync();

        // Out-of-range index and unused opcode are no-ops
        cmd(5, 9, 0, 0);
        expect_val("idx9_ovf", K_OVF, 3, 1);
        sync();
        cmd(1, 9, 0, 0);
        expect_val("idx9_run0", K_RUN, 0, 0);
        expect_val("idx9_run1", K_RUN, 1, 0);
        sync();
        cmd(7, 3, 0, 0);
        expect_val("op7_run", K_RUN, 3, 1);
        expect_val("op7_ovf", K_OVF, 3, 1);
        expect_val("op7_count", K_COUNT, 3, 3);
        sync();

        // Compare match at 100, then CLEAR
        do_reset();
        cmd(4, 0, 0, 100); sync();
        cmd(1, 0, 0, 0);   sync();
        run(99);
        expect_val("cmp_99", K_COUNT, 0, 99);
        expect_val("cmp_nomatch", K_MAT, 0, 0);
        sync();
        run(1);
        expect_val("cmp_100", K_COUNT, 0, 100);
        expect_val("cmp_match", K_MAT, 0, 1);
        sync();
        run(5);
        expect_val("cmp_sticky", K_MAT, 0, 1);
        expect_val("cmp_irq", K_IRQ, 0, 1);
        sync();
        cmd(0, 0, 0, 0);
        expect_val("clr_match", K_MAT, 0, 0);
        expect_val("clr_count", K_COUNT, 0, 0);
        expect_val("clr_run", K_RUN, 0, 0);
        sync();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
